// File: rtl/noc_pkg.sv
// rtl/noc_pkg.sv - shared flit layout constants and helpers for the butterfly-tree NoC
// Purpose: one place for the flit format {dest, payload} (dest in the MSBs) and
//          the statistics counter width, so every NoC block agrees on the layout.
// Ports:   none (package).
package noc_pkg;

    localparam int DATA_W   = 36;
    localparam int ADDR_W   = 4;
    localparam int PW       = DATA_W - ADDR_W;
    localparam int ADDR_MSB = DATA_W - 1;
    localparam int CNT_W    = 16;

    // Destination field of a flit at the default flit geometry.
    function automatic logic [ADDR_W-1:0] get_dest(input logic [DATA_W-1:0] flit);
        return flit[ADDR_MSB -: ADDR_W];
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with wrap-bit full/empty detection
// Purpose: small register-based FIFO used for both the TX flit queue and the
//          RX payload queue of the leaf network interface.
// Ports:
//   i_clk    clock, rising edge
//   i_rst_n  asynchronous active-low reset; empties the FIFO
//   i_push   write i_din (ignored when full)
//   i_din    write data
//   i_pop    drop the head entry (ignored when empty)
//   o_dout   head entry; undefined content while empty
//   o_full   no free entry
//   o_empty  no entry
module sync_fifo #(
    parameter int Width = 8,
    parameter int Depth = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [Width-1:0] i_din,
    input  logic             i_pop,
    output logic [Width-1:0] o_dout,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(Depth);

    // One extra MSB per pointer distinguishes full from empty when the
    // index bits match.
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [Width-1:0] mem_q [Depth];
    logic             do_push;
    logic             do_pop;

    always_comb begin
        o_empty  = (wr_ptr_q == rd_ptr_q);
        o_full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        do_push  = i_push && !o_full;
        do_pop   = i_pop && !o_empty;
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        o_dout   = mem_q[rd_ptr_q[AW-1:0]];
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: outputs of the interface are masked by valid.
    always_ff @(posedge i_clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= i_din;
        end
    end

endmodule

// File: rtl/pe_net_if.sv
// rtl/pe_net_if.sv - leaf network interface between one PE and one tree leaf port
// Purpose: packs PE payloads into {dest, payload} flits towards the tree,
//          filters flits arriving from the tree by destination and queues the
//          payloads for the PE. Self-addressed flits loop back internally.
// Ports:
//   i_sclk, i_reset                   clock / asynchronous active-low reset
//   i_pe_tx_data/dest/valid, o_pe_tx_ready      PE -> interface
//   o_net_data/_valid, i_net_data_ready         interface -> tree
//   i_net_data/_valid, o_net_data_ready         tree -> interface
//   o_pe_rx_data/valid, i_pe_rx_ready           interface -> PE
//   o_tx_count, o_rx_count            flits sent to tree / payloads queued for PE
//   o_misroute                        sticky: a flit for another address arrived
module pe_net_if
    import noc_pkg::*;
#(
    parameter int DataWidth = DATA_W,
    parameter int AddrWidth = ADDR_W,
    parameter int MyAddr    = 0,
    parameter int TxDepth   = 2,
    parameter int RxDepth   = 4
) (
    input  logic                           i_sclk,
    input  logic                           i_reset,
    input  logic [DataWidth-AddrWidth-1:0] i_pe_tx_data,
    input  logic [AddrWidth-1:0]           i_pe_tx_dest,
    input  logic                           i_pe_tx_valid,
    output logic                           o_pe_tx_ready,
    output logic [DataWidth-1:0]           o_net_data,
    output logic                           o_net_data_valid,
    input  logic                           i_net_data_ready,
    input  logic [DataWidth-1:0]           i_net_data,
    input  logic                           i_net_data_valid,
    output logic                           o_net_data_ready,
    output logic [DataWidth-AddrWidth-1:0] o_pe_rx_data,
    output logic                           o_pe_rx_valid,
    input  logic                           i_pe_rx_ready,
    output logic [CNT_W-1:0]               o_tx_count,
    output logic [CNT_W-1:0]               o_rx_count,
    output logic                           o_misroute
);

    localparam int PldW = DataWidth - AddrWidth;
    localparam logic [AddrWidth-1:0] MY_ADDR = AddrWidth'(MyAddr);

    // Readies are held low during reset and rise on the first clock after
    // release; this flop gates them.
    logic             ready_en_q, ready_en_d;
    logic [CNT_W-1:0] tx_count_q, tx_count_d;
    logic [CNT_W-1:0] rx_count_q, rx_count_d;
    logic             misroute_q, misroute_d;

    logic [DataWidth-1:0] tx_din, tx_dout;
    logic                 tx_push, tx_pop, tx_full, tx_empty;
    logic [PldW-1:0]      rx_din, rx_dout;
    logic                 rx_push, rx_pop, rx_full, rx_empty;

    logic head_loop;
    logic net_tx_fire;
    logic net_rx_fire;
    logic net_rx_hit;
    logic net_rx_miss;
    logic loop_fire;

    sync_fifo #(
        .Width (DataWidth),
        .Depth (TxDepth)
    ) u_tx_fifo (
        .i_clk   (i_sclk),
        .i_rst_n (i_reset),
        .i_push  (tx_push),
        .i_din   (tx_din),
        .i_pop   (tx_pop),
        .o_dout  (tx_dout),
        .o_full  (tx_full),
        .o_empty (tx_empty)
    );

    sync_fifo #(
        .Width (PldW),
        .Depth (RxDepth)
    ) u_rx_fifo (
        .i_clk   (i_sclk),
        .i_rst_n (i_reset),
        .i_push  (rx_push),
        .i_din   (rx_din),
        .i_pop   (rx_pop),
        .o_dout  (rx_dout),
        .o_full  (rx_full),
        .o_empty (rx_empty)
    );

    always_comb begin
        ready_en_d = 1'b1;

        // TX enqueue
        o_pe_tx_ready = ready_en_q && !tx_full;
        tx_din        = {i_pe_tx_dest, i_pe_tx_data};
        tx_push       = i_pe_tx_valid && o_pe_tx_ready;

        // TX head: self-addressed heads never drive the tree port.
        head_loop        = !tx_empty && (get_dest(tx_dout) == MY_ADDR);
        o_net_data_valid = !tx_empty && !head_loop;
        o_net_data       = o_net_data_valid ? tx_dout : '0;
        net_tx_fire      = o_net_data_valid && i_net_data_ready;

        // RX accept is driven only by registered FIFO state.
        o_net_data_ready = ready_en_q && !rx_full;
        net_rx_fire      = i_net_data_valid && o_net_data_ready;
        net_rx_hit       = net_rx_fire && (get_dest(i_net_data) == MY_ADDR);
        net_rx_miss      = net_rx_fire && (get_dest(i_net_data) != MY_ADDR);

        // Single RX write port: the network wins, the loopback head waits.
        loop_fire = head_loop && !rx_full && !net_rx_hit;
        rx_push   = net_rx_hit || loop_fire;
        rx_din    = net_rx_hit ? i_net_data[PldW-1:0] : tx_dout[PldW-1:0];
        tx_pop    = net_tx_fire || loop_fire;

        // RX dequeue
        o_pe_rx_valid = !rx_empty;
        o_pe_rx_data  = o_pe_rx_valid ? rx_dout : '0;
        rx_pop        = o_pe_rx_valid && i_pe_rx_ready;

        tx_count_d = net_tx_fire ? tx_count_q + 1'b1 : tx_count_q;
        rx_count_d = rx_push     ? rx_count_q + 1'b1 : rx_count_q;
        misroute_d = misroute_q || net_rx_miss;

        o_tx_count = tx_count_q;
        o_rx_count = rx_count_q;
        o_misroute = misroute_q;
    end

    always_ff @(posedge i_sclk or negedge i_reset) begin
        if (!i_reset) begin
            ready_en_q <= 1'b0;
            tx_count_q <= '0;
            rx_count_q <= '0;
            misroute_q <= 1'b0;
        end else begin
            ready_en_q <= ready_en_d;
            tx_count_q <= tx_count_d;
            rx_count_q <= rx_count_d;
            misroute_q <= misroute_d;
        end
    end

endmodule
